// File: rtl/axi_slv_pkg.sv
// Shared types and burst legality helper for the AXI burst slave memory.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // max_size is log2 of the data bus width in bytes.
    function automatic logic legal_burst(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst, input logic [2:0] max_size);
        logic ok;
        ok = (size <= max_size) && (burst != 2'b11);
        if (burst == WRAP) begin
            ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_beat_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] block;
    logic [ADDR_WIDTH-1:0] base;

    always_comb begin
        beat_bytes = ADDR_WIDTH'(1) << size;
        // Block size is a power of two for every legal wrap length, so a mask acts as the modulo.
        block      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        base       = start_addr & ~(block - ADDR_WIDTH'(1));
        case (burst)
            INCR:    next_addr = (cur_addr & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
            WRAP:    next_addr = base + ((cur_addr + beat_bytes - base) & (block - ADDR_WIDTH'(1)));
            default: next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI3-style slave with a byte-addressed memory and independent read/write burst engines.
module axi_burst_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [LEN_WIDTH-1:0]    ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         NB_LOG2   = $clog2(NB);
    localparam int         MEM_AW    = $clog2(MEM_BYTES);
    localparam int         MEM_WORDS = MEM_BYTES / NB;
    localparam logic [2:0] MAX_SIZE  = 3'(NB_LOG2);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> MEM_AW) == '0;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] mem_rd_q;

    wstate_t               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] wcur_q, wcur_d, wstart_q, wstart_d, wnext;
    logic [LEN_WIDTH-1:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  wbad_q, wbad_d, werr_q, werr_d;
    logic                  w_last, w_we;

    rstate_t               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] rcur_q, rcur_d, rstart_q, rstart_d, rnext, r_load_addr;
    logic [LEN_WIDTH-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic                  rbad_q, rbad_d, rlast_q, rlast_d, rok_q, rok_d;
    logic                  r_load, r_load_bad;

    axi_beat_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_waddr (
        .cur_addr(wcur_q), .start_addr(wstart_q), .len(wlen_q),
        .size(wsize_q), .burst(wburst_q), .next_addr(wnext)
    );

    axi_beat_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_raddr (
        .cur_addr(rcur_q), .start_addr(rstart_q), .len(rlen_q),
        .size(rsize_q), .burst(rburst_q), .next_addr(rnext)
    );

    always_comb begin
        wstate_d = wstate_q;
        awid_d   = awid_q;
        wcur_d   = wcur_q;
        wstart_d = wstart_q;
        wlen_d   = wlen_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        wcnt_d   = wcnt_q;
        wbad_d   = wbad_q;
        werr_d   = werr_q;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        w_last   = (wcnt_q == wlen_q);
        w_we     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    awid_d   = AWID;
                    wcur_d   = AWADDR;
                    wstart_d = AWADDR;
                    wlen_d   = AWLEN;
                    wsize_d  = AWSIZE;
                    wburst_d = AWBURST;
                    wcnt_d   = '0;
                    wbad_d   = !legal_burst(8'(AWLEN), AWSIZE, AWBURST, MAX_SIZE);
                    werr_d   = wbad_d;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    // An illegal burst still drains its beats so the master is never stalled.
                    w_we = !wbad_q && in_range(wcur_q);
                    if ((WID != awid_q) || !in_range(wcur_q) || (WLAST != w_last)) begin
                        werr_d = 1'b1;
                    end
                    wcur_d = wnext;
                    wcnt_d = wcnt_q + LEN_WIDTH'(1);
                    if (w_last || WLAST) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        rid_d       = rid_q;
        rcur_d      = rcur_q;
        rstart_d    = rstart_q;
        rlen_d      = rlen_q;
        rsize_d     = rsize_q;
        rburst_d    = rburst_q;
        rcnt_d      = rcnt_q;
        rbad_d      = rbad_q;
        rlast_d     = rlast_q;
        rresp_d     = rresp_q;
        rok_d       = rok_q;
        ARREADY     = 1'b0;
        r_load      = 1'b0;
        r_load_addr = rnext;
        r_load_bad  = rbad_q;
        case (rstate_q)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    rid_d       = ARID;
                    rcur_d      = ARADDR;
                    rstart_d    = ARADDR;
                    rlen_d      = ARLEN;
                    rsize_d     = ARSIZE;
                    rburst_d    = ARBURST;
                    rcnt_d      = '0;
                    rbad_d      = !legal_burst(8'(ARLEN), ARSIZE, ARBURST, MAX_SIZE);
                    r_load      = 1'b1;
                    r_load_addr = ARADDR;
                    r_load_bad  = rbad_d;
                    rstate_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        rcur_d = rnext;
                        rcnt_d = rcnt_q + LEN_WIDTH'(1);
                        r_load = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        // The beat presented next is loaded on the same edge that retires the current one.
        if (r_load) begin
            rlast_d = (rcnt_d == rlen_d);
            rok_d   = !r_load_bad && in_range(r_load_addr);
            rresp_d = rok_d ? OKAY : SLVERR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate_q <= W_IDLE;
            awid_q   <= '0;
            wcur_q   <= '0;
            wstart_q <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            wbad_q   <= 1'b0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            rcur_q   <= '0;
            rstart_q <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rcnt_q   <= '0;
            rbad_q   <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= '0;
            rok_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            awid_q   <= awid_d;
            wcur_q   <= wcur_d;
            wstart_q <= wstart_d;
            wlen_q   <= wlen_d;
            wsize_q  <= wsize_d;
            wburst_q <= wburst_d;
            wcnt_q   <= wcnt_d;
            wbad_q   <= wbad_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            rcur_q   <= rcur_d;
            rstart_q <= rstart_d;
            rlen_q   <= rlen_d;
            rsize_q  <= rsize_d;
            rburst_q <= rburst_d;
            rcnt_q   <= rcnt_d;
            rbad_q   <= rbad_d;
            rlast_q  <= rlast_d;
            rresp_q  <= rresp_d;
            rok_q    <= rok_d;
        end
    end

    // Unreset memory array; a read and a write on the same edge yields the pre-write data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (WSTRB[i]) begin
                    mem_q[wcur_q[MEM_AW-1:NB_LOG2]][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
        if (r_load) begin
            mem_rd_q <= mem_q[r_load_addr[MEM_AW-1:NB_LOG2]];
        end
    end

    assign BID   = awid_q;
    assign BRESP = werr_q ? SLVERR : OKAY;
    assign RID   = rid_q;
    assign RDATA = rok_q ? mem_rd_q : '0;
    assign RRESP = rresp_q;
    assign RLAST = rlast_q;
    assign RVALID = (rstate_q == R_DATA);

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: burst types, strobes, errors, backpressure, reset.
module tb_axi_burst_slave_mem;

    localparam int TMO = 50;

    logic        clk;
    logic        resetn;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] ed [16];
    logic [1:0]  er [16];

    axi_burst_slave_mem dut (
        .clk(clk), .resetn(resetn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input int nbeats, input int bstall,
                             input logic [1:0] exp_resp);
        int t;
        AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWID = id; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < TMO) begin @(negedge clk); t++; end
        chk("awready", 32'(AWREADY), 32'd1);
        @(negedge clk);
        AWVALID = 1'b0;
        chk("wready_latency", 32'(WREADY), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            WDATA = wd[b]; WSTRB = ws[b]; WID = id; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            t = 0;
            while (!WREADY && t < TMO) begin @(negedge clk); t++; end
            chk("wready", 32'(WREADY), 32'd1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("bvalid_latency", 32'(BVALID), 32'd1);
        for (int s = 0; s < bstall; s++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(BVALID), 32'd1);
        end
        chk("bresp", 32'(BRESP), 32'(exp_resp));
        chk("bid", 32'(BID), 32'(id));
        $display("WRITE addr=%h len=%0d burst=%0d beats=%0d bresp=%0d", addr, len, burst, nbeats, BRESP);
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        chk("bvalid_clear", 32'(BVALID), 32'd0);
    endtask

    // Expected beats come from ed/er; optional RREADY stall before accepting beat stall_beat.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int stall_beat, input int stall_cyc);
        int t;
        ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARID = id; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < TMO) begin @(negedge clk); t++; end
        chk("arready", 32'(ARREADY), 32'd1);
        @(negedge clk);
        ARVALID = 1'b0;
        chk("rvalid_latency", 32'(RVALID), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!RVALID && t < TMO) begin @(negedge clk); t++; end
            chk("rvalid", 32'(RVALID), 32'd1);
            chk("rdata", RDATA, ed[b]);
            chk("rresp", 32'(RRESP), 32'(er[b]));
            chk("rlast", 32'(RLAST), 32'(b == int'(len)));
            chk("rid", 32'(RID), 32'(id));
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk);
                    chk("rdata_hold", RDATA, ed[b]);
                    chk("rlast_hold", 32'(RLAST), 32'(b == int'(len)));
                    chk("rvalid_hold", 32'(RVALID), 32'd1);
                end
            end
            RREADY = 1'b1;
            @(negedge clk);
            RREADY = 1'b0;
        end
        chk("rvalid_end", 32'(RVALID), 32'd0);
        $display("READ  addr=%h len=%0d burst=%0d first=%h", addr, len, burst, ed[0]);
    endtask

    initial begin
        resetn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_bid_bresp", {26'd0, BID, BRESP}, 32'd0);
        chk("rst_rid_rresp", {26'd0, RID, RRESP}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: INCR write and read back
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        axi_write(32'h100, 4'd3, 2'b01, 4'd5, 4, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin ed[i] = wd[i]; er[i] = 2'b00; end
        axi_read(32'h100, 4'd3, 2'b01, 4'd6, -1, 0);

        // 2: WRAP read starting mid-block
        ed[0] = 32'h44444444; ed[1] = 32'h11111111; ed[2] = 32'h22222222; ed[3] = 32'h33333333;
        axi_read(32'h10C, 4'd3, 2'b10, 4'd7, -1, 0);

        // 3: strobed FIXED write over a cleared word, with B backpressure on the clear
        wd[0] = 32'h0; ws[0] = 4'hF;
        axi_write(32'h200, 4'd0, 2'b01, 4'd1, 1, 3, 2'b00);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h1; wd[1] = 32'hAABBCCDD; ws[1] = 4'h8;
        axi_write(32'h200, 4'd1, 2'b00, 4'd2, 2, 0, 2'b00);
        ed[0] = 32'hAA0000DD; er[0] = 2'b00;
        axi_read(32'h200, 4'd0, 2'b01, 4'd2, -1, 0);

        // 4a: INCR running past the end of memory
        wd[0] = 32'h5A5A5A5A; wd[1] = 32'h6B6B6B6B; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'hFFC, 4'd1, 2'b01, 4'd3, 2, 0, 2'b10);
        ed[0] = 32'h5A5A5A5A; er[0] = 2'b00; ed[1] = 32'h0; er[1] = 2'b10;
        axi_read(32'hFFC, 4'd1, 2'b01, 4'd3, -1, 0);

        // 4b: reserved burst type leaves memory untouched
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(32'h100, 4'd0, 2'b11, 4'd4, 1, 0, 2'b10);
        ed[0] = 32'h11111111; er[0] = 2'b00;
        axi_read(32'h100, 4'd0, 2'b01, 4'd4, -1, 0);

        // 4c: WLAST on the first beat of a four-beat burst
        wd[0] = 32'h01010101; ws[0] = 4'hF;
        axi_write(32'h400, 4'd3, 2'b01, 4'd8, 1, 0, 2'b10);

        // 5a: RREADY held low for three cycles mid-burst
        ed[0] = 32'h11111111; ed[1] = 32'h22222222; ed[2] = 32'h33333333; ed[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) er[i] = 2'b00;
        axi_read(32'h100, 4'd3, 2'b01, 4'd9, 1, 3);

        // 5b: read load and write to 0x300 on the same edge
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        axi_write(32'h300, 4'd0, 2'b01, 4'd10, 1, 0, 2'b00);
        AWADDR = 32'h300; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 4'd11; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WID = 4'd11; WLAST = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h300; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 4'd12; ARVALID = 1'b1;
        chk("coll_wready", 32'(WREADY), 32'd1);
        chk("coll_arready", 32'(ARREADY), 32'd1);
        @(negedge clk);
        WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
        chk("coll_rvalid", 32'(RVALID), 32'd1);
        chk("coll_rdata_old", RDATA, 32'h12345678);
        chk("coll_bvalid", 32'(BVALID), 32'd1);
        chk("coll_bresp", 32'(BRESP), 32'd0);
        $display("COLLIDE addr=00000300 rdata=%h bresp=%0d", RDATA, BRESP);
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0; BREADY = 1'b0;
        ed[0] = 32'hCAFEF00D; er[0] = 2'b00;
        axi_read(32'h300, 4'd0, 2'b01, 4'd12, -1, 0);

        // 6: asynchronous reset during the second write beat
        AWADDR = 32'h500; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 4'd13; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        WDATA = 32'h77777777; WSTRB = 4'hF; WID = 4'd13; WLAST = 1'b0; WVALID = 1'b1;
        @(negedge clk);
        WDATA = 32'h88888888;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        WVALID = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_bvalid", 32'(BVALID), 32'd0);
        chk("rst_mid_awready", 32'(AWREADY), 32'd1);
        chk("rst_mid_wready", 32'(WREADY), 32'd0);
        $display("RESET mid-burst addr=00000500 bvalid=%0d awready=%0d", BVALID, AWREADY);
        wd[0] = 32'h01020304; wd[1] = 32'h05060708; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'h500, 4'd1, 2'b01, 4'd14, 2, 0, 2'b00);
        ed[0] = 32'h01020304; ed[1] = 32'h05060708; er[0] = 2'b00; er[1] = 2'b00;
        axi_read(32'h500, 4'd1, 2'b01, 4'd14, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
